// File: rtl/pmod_pulse_pkg.sv
// Shared types and widths for the PMOD pulse transmitter.
// Holds the FSM state enum and the phase/count widths.
package pmod_pulse_pkg;

  localparam int PHASE_W = 8;
  localparam int COUNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HIGH,
    S_LOW,
    S_DONE
  } state_t;

endpackage

// File: rtl/pmod_pulse_tx_timer.sv
// Loadable down-counter timing the HIGH and LOW phases of a pulse.
// Ports: i_clk, i_rst (sync, high), i_load, i_load_val, o_tc (count == 1).
module pulse_phase_timer
  import pmod_pulse_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic [PHASE_W-1:0] i_load_val,
  output logic               o_tc
);

  localparam logic [PHASE_W-1:0] ONE = PHASE_W'(1);

  logic [PHASE_W-1:0] r_cnt;

  // Parks at zero so a stale timer never wraps to 255.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - ONE;
    end
  end

  assign o_tc = (r_cnt == ONE);

endmodule

// File: rtl/pmod_pulse_tx.sv
// Emits a burst of i_COUNT pulses (HIGH_CYC high, LOW_CYC low) on a PMOD pin.
// Ports: i_SCLK, i_RESET_SYS, i_START/i_COUNT in; o_READY, o_PMOD1_P1,
// o_BUSY, o_DONE, o_SENT out, all from flops.
module pmod_pulse_tx
  import pmod_pulse_pkg::*;
#(
  parameter int HIGH_CYC = 1,
  parameter int LOW_CYC  = 3
) (
  input  logic               i_SCLK,
  input  logic               i_RESET_SYS,
  input  logic               i_START,
  input  logic [COUNT_W-1:0] i_COUNT,
  output logic               o_READY,
  output logic               o_PMOD1_P1,
  output logic               o_BUSY,
  output logic               o_DONE,
  output logic [COUNT_W-1:0] o_SENT
);

  localparam logic [PHASE_W-1:0] HIGH_LD = PHASE_W'(HIGH_CYC);
  localparam logic [PHASE_W-1:0] LOW_LD  = PHASE_W'(LOW_CYC);
  localparam logic [COUNT_W-1:0] C_ONE   = COUNT_W'(1);

  state_t             r_state;
  state_t             w_next;
  logic [COUNT_W-1:0] r_remain;
  logic [COUNT_W-1:0] r_sent;
  logic               r_ready;
  logic               r_p1;
  logic               r_busy;
  logic               r_done;
  logic               w_accept;
  logic               w_load;
  logic [PHASE_W-1:0] w_load_val;
  logic               w_pulse_end;
  logic               w_tc;

  pulse_phase_timer u_timer (
    .i_clk      (i_SCLK),
    .i_rst      (i_RESET_SYS),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_tc       (w_tc)
  );

  assign w_accept = (r_state == S_IDLE) && i_START;

  always_comb begin
    w_next      = r_state;
    w_load      = 1'b0;
    w_load_val  = HIGH_LD;
    w_pulse_end = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_START) begin
          w_load = 1'b1;
          if (i_COUNT != '0) w_next = S_HIGH;
          else               w_next = S_DONE;
        end
      end
      S_HIGH: begin
        if (w_tc) begin
          w_next      = S_LOW;
          w_load      = 1'b1;
          w_load_val  = LOW_LD;
          w_pulse_end = 1'b1;
        end
      end
      S_LOW: begin
        if (w_tc) begin
          if (r_remain != '0) begin
            w_next = S_HIGH;
            w_load = 1'b1;
          end else begin
            w_next = S_DONE;
          end
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up
  // with the state register without any input-to-output path.
  always_ff @(posedge i_SCLK) begin
    if (i_RESET_SYS) begin
      r_state  <= S_IDLE;
      r_remain <= '0;
      r_sent   <= '0;
      r_ready  <= 1'b1;
      r_p1     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_remain <= i_COUNT;
        r_sent   <= '0;
      end else if (w_pulse_end) begin
        r_remain <= r_remain - C_ONE;
        r_sent   <= r_sent + C_ONE;
      end
      r_ready <= (w_next == S_IDLE);
      r_p1    <= (w_next == S_HIGH);
      r_busy  <= (w_next == S_HIGH) || (w_next == S_LOW);
      r_done  <= (w_next == S_DONE);
    end
  end

  assign o_READY    = r_ready;
  assign o_PMOD1_P1 = r_p1;
  assign o_BUSY     = r_busy;
  assign o_DONE     = r_done;
  assign o_SENT     = r_sent;

endmodule
